// File: rtl/video_stream_in_pkg.sv
// video_stream_in_pkg: shared state encoding, channel sizes and quantizer for video ingress
package video_stream_in_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_e;
  localparam int PIX_W  = 8;
  localparam int CH_W   = 16;
  localparam int NUM_CH = 3;
  typedef enum logic [3:0] {
    Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7,
    Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15
  } quant_e;
  // q fractional bits: an 8-bit pixel is treated as 8 fractional bits, so shift by (q - 8)
  function automatic logic [CH_W-1:0] quantize(input logic [PIX_W-1:0] p, input quant_e q);
    logic [CH_W-1:0] w;
    w = {8'b0, p};
    return q == Q0 ? 16'd0 : q <= Q8 ? w >> (4'd8 - q) : w << (q - 4'd8);
  endfunction
endpackage

// File: rtl/video_in_fifo.sv
// video_in_fifo: synchronous first-word-fall-through FIFO
//   system_clk/srst : clock, synchronous active-high reset (flushes contents)
//   push/wdata      : write side, ignored when full unless popping in the same cycle
//   pop/rdata       : read side, rdata shows the head entry whenever not empty
//   count/empty/almost_full : occupancy, almost_full at depth-2 or more
module video_in_fifo #(
  parameter int W  = 48,
  parameter int AW = 4
) (
  input  logic          system_clk,
  input  logic          srst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          almost_full
);
  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    do_pop  = pop & (cnt_q != '0);
    do_push = push & ((cnt_q != (AW+1)'(2**AW)) | do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge system_clk) begin
    if (srst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge system_clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  assign rdata       = mem_q[rd_q];
  assign count       = cnt_q;
  assign empty       = cnt_q == '0;
  assign almost_full = cnt_q >= (AW+1)'(2**AW - 2);
endmodule

// File: rtl/video_stream_in.sv
// video_stream_in: AXI4-Stream video ingress with geometry checks, 8->16 bit quantization and output FIFO
//   system_clk/srst        : clock, synchronous active-high reset
//   video_input_req        : arm for a new frame (clears counters and sticky errors)
//   fea_in_quant_size      : fractional bits of the 16-bit output format
//   video_col_size/row_size: expected frame geometry
//   axi_stream_*           : slave stream, tdata = {X, ch2, ch1, ch0}, tuser = SOF, tlast = EOL
//   video_valid/data/ready : packed {ch2, ch1, ch0} output handshake
//   frame_done/frame_abort : one-cycle pulses; eol_err/sof_err : sticky error flags
module video_stream_in
  import video_stream_in_pkg::*;
#(
  parameter int COL_W        = 10,
  parameter int ROW_W        = 10,
  parameter int FIFO_DEPTH_W = 4
) (
  input  logic             system_clk,
  input  logic             srst,
  input  logic             video_input_req,
  input  logic [3:0]       fea_in_quant_size,
  input  logic [COL_W-1:0] video_col_size,
  input  logic [ROW_W-1:0] video_row_size,
  input  logic             axi_stream_tvalid,
  input  logic [31:0]      axi_stream_tdata,
  input  logic [3:0]       axi_stream_tkeep,
  input  logic             axi_stream_tlast,
  input  logic             axi_stream_tuser,
  output logic             axi_stream_tready,
  output logic             video_valid,
  output logic [47:0]      video_data,
  input  logic             video_ready,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             eol_err,
  output logic             sof_err
);
  state_e                    state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d, eff_col;
  logic [ROW_W-1:0]          row_q, row_d, eff_row;
  logic                      qv_q, qv_d;
  logic [NUM_CH*CH_W-1:0]    qd_q, qd_d, fifo_dout;
  logic                      frame_done_q, frame_done_d, frame_abort_q, frame_abort_d;
  logic                      eol_err_q, eol_err_d, sof_err_q, sof_err_d;
  logic                      acc, in_frame, restart, eol_pos, bad_eol, store, last_pix;
  logic                      fifo_af, fifo_empty;
  logic [FIFO_DEPTH_W:0]     fifo_count;
  logic                      unused_ok;
  quant_e                    qs;
  assign qs                = quant_e'(fea_in_quant_size);
  assign axi_stream_tready = (state_q == WAIT_SOF || state_q == ACTIVE) && !fifo_af;
  assign unused_ok         = ^{axi_stream_tkeep, axi_stream_tdata[31:24], fifo_count};
  always_comb begin
    acc      = axi_stream_tvalid & axi_stream_tready;
    // a beat belongs to the frame if we are active or it opens a (new) frame
    in_frame = acc & ((state_q == ACTIVE) | axi_stream_tuser);
    restart  = in_frame & axi_stream_tuser;
    eff_col  = restart ? '0 : col_q;
    eff_row  = restart ? '0 : row_q;
    eol_pos  = eff_col == video_col_size - COL_W'(1);
    bad_eol  = in_frame & (state_q == ACTIVE) & (axi_stream_tlast != eol_pos);
    store    = in_frame & ~bad_eol & ~video_input_req;
    last_pix = store & eol_pos & (eff_row == video_row_size - ROW_W'(1));
    col_d    = (video_input_req | bad_eol) ? '0 : store ? (eol_pos ? '0 : eff_col + COL_W'(1)) : col_q;
    row_d    = (video_input_req | bad_eol | last_pix) ? '0 :
               store ? (eol_pos ? eff_row + ROW_W'(1) : eff_row) : row_q;
    state_d  = video_input_req ? WAIT_SOF : last_pix ? DONE : bad_eol ? WAIT_SOF :
               store ? ACTIVE : state_q;
    sof_err_d     = ~video_input_req & (sof_err_q |
                    (restart & (state_q == ACTIVE) & ((col_q != '0) | (row_q != '0))));
    eol_err_d     = ~video_input_req & (eol_err_q | bad_eol);
    frame_done_d  = last_pix;
    frame_abort_d = bad_eol & ~video_input_req;
    qv_d = store;
    qd_d = store ? {quantize(axi_stream_tdata[23:16], qs),
                    quantize(axi_stream_tdata[15:8], qs),
                    quantize(axi_stream_tdata[7:0], qs)} : qd_q;
  end
  always_ff @(posedge system_clk) begin
    if (srst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      qv_q          <= 1'b0;
      qd_q          <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      eol_err_q     <= 1'b0;
      sof_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      qv_q          <= qv_d;
      qd_q          <= qd_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      eol_err_q     <= eol_err_d;
      sof_err_q     <= sof_err_d;
    end
  end
  video_in_fifo #(.W(NUM_CH*CH_W), .AW(FIFO_DEPTH_W)) u_fifo (
    .system_clk  (system_clk),
    .srst        (srst),
    .push        (qv_q),
    .wdata       (qd_q),
    .pop         (~fifo_empty & video_ready),
    .rdata       (fifo_dout),
    .count       (fifo_count),
    .empty       (fifo_empty),
    .almost_full (fifo_af)
  );
  // memory is not reset, so mask the head while empty
  assign video_valid = ~fifo_empty;
  assign video_data  = fifo_empty ? '0 : fifo_dout;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign eol_err     = eol_err_q;
  assign sof_err     = sof_err_q;
endmodule

// File: tb/tb_video_stream_in.sv
// tb_video_stream_in: directed self-checking bench for video_stream_in
module tb_video_stream_in;
  logic        system_clk = 0, srst = 1, video_input_req = 0;
  logic [3:0]  quant = 0;
  logic [9:0]  col_size = 1, row_size = 1;
  logic        tvalid = 0, tlast = 0, tuser = 0, tready;
  logic [31:0] tdata = 0;
  logic        video_valid, video_ready = 1;
  logic [47:0] video_data;
  logic        frame_done, frame_abort, eol_err, sof_err;
  int          nvec = 0, nerr = 0, sent_cnt = 0, got_base = 0;
  logic [47:0] got[$];
  logic [47:0] exp_q[$];

  always #5 system_clk = ~system_clk;

  video_stream_in dut (
    .system_clk        (system_clk),
    .srst              (srst),
    .video_input_req   (video_input_req),
    .fea_in_quant_size (quant),
    .video_col_size    (col_size),
    .video_row_size    (row_size),
    .axi_stream_tvalid (tvalid),
    .axi_stream_tdata  (tdata),
    .axi_stream_tkeep  (4'hF),
    .axi_stream_tlast  (tlast),
    .axi_stream_tuser  (tuser),
    .axi_stream_tready (tready),
    .video_valid       (video_valid),
    .video_data        (video_data),
    .video_ready       (video_ready),
    .frame_done        (frame_done),
    .frame_abort       (frame_abort),
    .eol_err           (eol_err),
    .sof_err           (sof_err)
  );

  always @(negedge system_clk) if (video_valid && video_ready) got.push_back(video_data);

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    nvec++;
    if (got_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic u);
    int n;
    n = 0;
    tvalid = 1; tdata = d; tlast = l; tuser = u;
    @(negedge system_clk);
    while (!tready && n < 300) begin
      @(negedge system_clk);
      n++;
    end
    if (!tready) chk("tready_timeout", tready, 1);
    @(posedge system_clk); #1;
    tvalid = 0;
    sent_cnt++;
  endtask

  task automatic pulse_req();
    video_input_req = 1;
    @(posedge system_clk); #1;
    video_input_req = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (got.size() - got_base < exp_q.size() && n < 500) begin
      @(posedge system_clk);
      n++;
    end
    repeat (4) @(posedge system_clk);
    #1;
    chk({tag, "_count"}, got.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && got_base + i < got.size(); i++)
      chk(tag, got[got_base + i], exp_q[i]);
    got_base = got.size();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge system_clk);
    #1 srst = 0;
    chk("rst_tready", tready, 0);
    chk("rst_valid", video_valid, 0);
    chk("rst_data", video_data, 0);
    chk("rst_pulses", {frame_done, frame_abort}, 0);
    chk("rst_flags", {eol_err, sof_err}, 0);
    tvalid = 1;
    @(posedge system_clk); #1;
    chk("idle_tready", tready, 0);
    tvalid = 0;

    // basic 4x2 frame at q=4
    pulse_req();
    quant = 4; col_size = 4; row_size = 2;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'h00FF8010, i % 4 == 3, i == 0);
      exp_q.push_back(48'h000F_0008_0001);
      if (i == 0) chk("lat_not_yet", video_valid, 0);
      if (i == 1) begin
        chk("lat_valid", video_valid, 1);
        chk("lat_data", video_data, 48'h000F_0008_0001);
      end
    end
    chk("t1_frame_done", frame_done, 1);
    @(posedge system_clk); #1;
    chk("t1_done_pulse_end", frame_done, 0);
    chk("t1_done_tready", tready, 0);
    drain("t1_out");

    // discarded beats before SOF, 2x1 frame at q=8
    pulse_req();
    quant = 8; col_size = 2; row_size = 1;
    for (int i = 0; i < 3; i++) send_beat(32'h11111111, 0, 0);
    send_beat(32'h00030201, 0, 1);
    send_beat(32'h00060504, 1, 0);
    chk("t2_frame_done", frame_done, 1);
    exp_q.push_back(48'h0003_0002_0001);
    exp_q.push_back(48'h0006_0005_0004);
    drain("t2_out");

    // early tlast, then mid-frame SOF
    pulse_req();
    col_size = 4; row_size = 2;
    send_beat(32'h1, 0, 1);
    send_beat(32'h2, 0, 0);
    send_beat(32'h3, 1, 0);
    chk("t3_abort", frame_abort, 1);
    chk("t3_eol_err", eol_err, 1);
    @(posedge system_clk); #1;
    chk("t3_abort_end", frame_abort, 0);
    chk("t3_wait_sof_tready", tready, 1);
    send_beat(32'h10, 0, 1);
    send_beat(32'h20, 0, 1);
    chk("t3_sof_err", sof_err, 1);
    chk("t3_eol_sticky", eol_err, 1);
    exp_q.push_back(48'h1);
    exp_q.push_back(48'h2);
    exp_q.push_back(48'h10);
    exp_q.push_back(48'h20);
    drain("t3_out");
    pulse_req();
    chk("t3_flags_cleared", {eol_err, sof_err}, 0);

    // quantizer sizes on 1x1 frames
    col_size = 1; row_size = 1;
    pulse_req(); quant = 0;
    send_beat(32'h00A5A5A5, 1, 1);
    chk("q0_done", frame_done, 1);
    exp_q.push_back(48'h0000_0000_0000);
    pulse_req(); quant = 8;
    send_beat(32'h00A5A5A5, 1, 1);
    exp_q.push_back(48'h00A5_00A5_00A5);
    pulse_req(); quant = 12;
    send_beat(32'h00A5A5A5, 1, 1);
    exp_q.push_back(48'h0A50_0A50_0A50);
    drain("quant_out");

    // backpressure: 4x4 frame, output stalled for 40 cycles
    pulse_req();
    quant = 8; col_size = 4; row_size = 4;
    video_ready = 0;
    sent_cnt = 0;
    for (int i = 0; i < 16; i++)
      exp_q.push_back({8'h0, 8'(i + 32), 8'h0, 8'(i + 16), 8'h0, 8'(i)});
    fork
      for (int i = 0; i < 16; i++)
        send_beat({8'hEE, 8'(i + 32), 8'(i + 16), 8'(i)}, i % 4 == 3, i == 0);
      begin
        repeat (40) @(posedge system_clk);
        #1;
        chk("bp_tready_low", tready, 0);
        chk("bp_accepted", sent_cnt, 15);
        chk("bp_head_held", video_data, {16'd32, 16'd16, 16'd0});
        video_ready = 1;
      end
    join
    drain("bp_out");

    // srst mid-frame with 5 pixels buffered
    pulse_req();
    col_size = 8; row_size = 2; quant = 8;
    video_ready = 0;
    send_beat(32'h1, 0, 1);
    send_beat(32'h2, 0, 0);
    send_beat(32'h3, 0, 1);
    send_beat(32'h4, 0, 0);
    send_beat(32'h5, 0, 0);
    chk("rs_sof_err", sof_err, 1);
    @(posedge system_clk); #1;
    chk("rs_buffered", video_valid, 1);
    srst = 1;
    @(posedge system_clk); #1;
    chk("rs_valid", video_valid, 0);
    chk("rs_tready", tready, 0);
    chk("rs_flags", {eol_err, sof_err, frame_done, frame_abort}, 0);
    srst = 0;
    tvalid = 1;
    video_ready = 1;
    repeat (3) @(posedge system_clk);
    #1;
    chk("rs_idle_tready", tready, 0);
    chk("rs_idle_valid", video_valid, 0);
    chk("rs_no_output", got.size() - got_base, 0);
    tvalid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
